// File: rtl/inst_mem_axi_slave_if.sv
// AXI4 bus bundle between the core's fetch/data master and the program-memory
// slave. Signal names match the original flat port list.
interface inst_mem_axi_slave_if #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    // write address
    logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [7:0]                        S_AXI_AWLEN;
    logic [1:0]                        S_AXI_AWBURST;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    // write data
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WLAST;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    // write response
    logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    // read address
    logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [7:0]                        S_AXI_ARLEN;
    logic [1:0]                        S_AXI_ARBURST;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    // read data
    logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RLAST;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/inst_mem_axi_slave.sv
// AXI4 slave serving a word-addressed on-chip program memory at the core's
// reset-PC window. Independent read and write FSMs, one outstanding
// transaction each; out-of-window bursts answer DECERR and touch nothing.
module inst_mem_axi_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_WORDS_LOG2   = 12,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h2000_0000
) (
    input  logic                 CCLK,
    input  logic                 CRST,
    inst_mem_axi_slave_if.slave  s_axi
);
    localparam int DEPTH     = 1 << C_MEM_WORDS_LOG2;
    localparam int TAG_LSB   = C_MEM_WORDS_LOG2 + 2;
    localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;

    typedef logic [C_MEM_WORDS_LOG2-1:0] idx_t;
    localparam idx_t IDX_ONE = idx_t'(1);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

    // read path state
    r_state_e                      r_state_q, r_state_d;
    logic                          arready_q, arready_d;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    idx_t                          r_idx_q, r_idx_d;
    logic [7:0]                    r_len_q, r_len_d;
    logic [7:0]                    r_beat_q, r_beat_d;
    logic                          r_fixed_q, r_fixed_d;
    logic                          r_ok_q, r_ok_d;
    logic                          r_wait_q, r_wait_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                          rd_en;

    // write path state
    w_state_e                      w_state_q, w_state_d;
    logic                          awready_q, awready_d;
    logic [C_S_AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
    idx_t                          w_idx_q, w_idx_d;
    logic [7:0]                    w_len_q, w_len_d;
    logic [7:0]                    w_beat_q, w_beat_d;
    logic                          w_fixed_q, w_fixed_d;
    logic                          w_ok_q, w_ok_d;
    logic                          w_err_q, w_err_d;
    logic                          mem_we;

    // Byte offset within a word carries no meaning for a word-addressed memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Read FSM next state. R_FETCH lasts two cycles (r_wait_q marks the
    // second) so the first beat appears two edges after the AR handshake;
    // later beats reload the read register on the handshake cycle itself.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_fixed_d = r_fixed_q;
        r_ok_d    = r_ok_q;
        r_wait_d  = r_wait_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && s_axi.S_AXI_ARVALID) begin
                    arready_d = 1'b0;
                    r_state_d = R_FETCH;
                    r_id_d    = s_axi.S_AXI_ARID;
                    r_idx_d   = s_axi.S_AXI_ARADDR[TAG_LSB-1:2];
                    r_len_d   = s_axi.S_AXI_ARLEN;
                    r_beat_d  = '0;
                    r_fixed_d = (s_axi.S_AXI_ARBURST == 2'b00);
                    r_ok_d    = (s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB] ==
                                 C_BASE_ADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB]);
                    r_wait_d  = 1'b0;
                end
            end
            R_FETCH: begin
                rd_en    = 1'b1;
                r_wait_d = 1'b1;
                if (r_wait_q) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    if (r_beat_q == r_len_q) begin
                        r_state_d = R_IDLE;
                        arready_d = 1'b1;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                        if (!r_fixed_q) begin
                            r_idx_d = r_idx_q + IDX_ONE;
                        end
                        rd_en = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Reads see the array before this edge's write lands: read-first.
        rd_data_d = rd_en ? mem[r_idx_d] : rd_data_q;
    end

    // Write FSM next state and memory write enable.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_fixed_d = w_fixed_q;
        w_ok_d    = w_ok_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awready_q && s_axi.S_AXI_AWVALID) begin
                    awready_d = 1'b0;
                    w_state_d = W_DATA;
                    w_id_d    = s_axi.S_AXI_AWID;
                    w_idx_d   = s_axi.S_AXI_AWADDR[TAG_LSB-1:2];
                    w_len_d   = s_axi.S_AXI_AWLEN;
                    w_beat_d  = '0;
                    w_fixed_d = (s_axi.S_AXI_AWBURST == 2'b00);
                    w_ok_d    = (s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB] ==
                                 C_BASE_ADDR[C_S_AXI_ADDR_WIDTH-1:TAG_LSB]);
                    w_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (s_axi.S_AXI_WVALID) begin
                    mem_we = w_ok_q && !CRST;
                    if (w_beat_q == w_len_q) begin
                        w_err_d   = w_err_q | !s_axi.S_AXI_WLAST;
                        w_state_d = W_RESP;
                    end else begin
                        w_err_d  = w_err_q | s_axi.S_AXI_WLAST;
                        w_beat_d = w_beat_q + 8'd1;
                        if (!w_fixed_q) begin
                            w_idx_d = w_idx_q + IDX_ONE;
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                    awready_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Control registers: synchronous reset returns both paths to idle.
    always_ff @(posedge CCLK) begin
        if (CRST) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            r_id_q    <= '0;
            r_beat_q  <= '0;
            r_ok_q    <= 1'b0;
            r_wait_q  <= 1'b0;
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            w_id_q    <= '0;
            w_beat_q  <= '0;
            w_ok_q    <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            r_id_q    <= r_id_d;
            r_beat_q  <= r_beat_d;
            r_ok_q    <= r_ok_d;
            r_wait_q  <= r_wait_d;
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            w_id_q    <= w_id_d;
            w_beat_q  <= w_beat_d;
            w_ok_q    <= w_ok_d;
            w_err_q   <= w_err_d;
        end
    end

    // Datapath registers; only meaningful while their FSM is busy.
    always_ff @(posedge CCLK) begin
        r_idx_q   <= r_idx_d;
        r_len_q   <= r_len_d;
        r_fixed_q <= r_fixed_d;
        rd_data_q <= rd_data_d;
        w_idx_q   <= w_idx_d;
        w_len_q   <= w_len_d;
        w_fixed_q <= w_fixed_d;
    end

    // Memory write port with per-byte lane enables; contents are never reset.
    always_ff @(posedge CCLK) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (s_axi.S_AXI_WSTRB[i]) begin
                    mem[w_idx_q][8*i +: 8] <= s_axi.S_AXI_WDATA[8*i +: 8];
                end
            end
        end
    end

    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
    assign s_axi.S_AXI_RID     = r_id_q;
    assign s_axi.S_AXI_RDATA   = (s_axi.S_AXI_RVALID && r_ok_q) ? rd_data_q : '0;
    assign s_axi.S_AXI_RRESP   = (s_axi.S_AXI_RVALID && !r_ok_q) ? 2'b11 : 2'b00;
    assign s_axi.S_AXI_RLAST   = s_axi.S_AXI_RVALID && (r_beat_q == r_len_q);

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = (w_state_q == W_DATA);
    assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
    assign s_axi.S_AXI_BID     = w_id_q;
    assign s_axi.S_AXI_BRESP   = !s_axi.S_AXI_BVALID ? 2'b00 :
                                 !w_ok_q             ? 2'b11 :
                                 w_err_q             ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_inst_mem_axi_slave.sv
// Self-checking bench for inst_mem_axi_slave: directed load/fetch, strobe,
// decode-error, burst-wrap and reset cases plus randomized traffic, all
// checked against a word-array model of the program memory.
module tb_inst_mem_axi_slave;
    localparam int          DEPTH     = 4096;
    localparam int          WIN_BYTES = DEPTH * 4;
    localparam logic [31:0] BASE      = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_mem_axi_slave_if #(
        .C_S_AXI_ID_WIDTH  (1),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32)
    ) bus ();

    inst_mem_axi_slave #(
        .C_S_AXI_ID_WIDTH  (1),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .C_MEM_WORDS_LOG2  (12),
        .C_BASE_ADDR       (BASE)
    ) dut (
        .CCLK (clk),
        .CRST (rst),
        .s_axi(bus)
    );

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic        wl [256];
    logic [31:0] last_rdata;
    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a / WIN_BYTES) == (BASE / WIN_BYTES);
    endfunction

    // Word touched by beat i of a burst starting at a.
    function automatic int unsigned beat_word(input logic [31:0] a, input logic [1:0] burst,
                                              input int unsigned i);
        int unsigned w;
        w = (a >> 2) % 32'(DEPTH);
        if (burst == 2'b00) return w;
        return (w + i) % DEPTH;
    endfunction

    task automatic apply_reset(input int unsigned n);
        rst = 1'b1;
        repeat (n) tick();
        chk("rst_outputs", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                                bus.S_AXI_BRESP, bus.S_AXI_BID, bus.S_AXI_ARREADY,
                                bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RLAST,
                                bus.S_AXI_RID}), 0);
        chk("rst_rdata", bus.S_AXI_RDATA, 0);
        rst = 1'b0;
        chk("ready_before_edge", 32'({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}), 0);
        tick();
        chk("ready_after_reset", 32'({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}), 3);
    endtask

    // Write burst from wd/ws/wl[0..len]; updates the model and checks B.
    task automatic axi_write(input logic id, input logic [31:0] addr, input int unsigned len,
                             input logic [1:0] burst, input bit gaps, input int unsigned bdelay);
        bit          ok;
        bit          err;
        logic [1:0]  exp_resp;
        int unsigned n;
        int unsigned w;
        ok  = in_win(addr);
        err = 1'b0;
        for (int unsigned i = 0; i <= len; i++) err = err | ((i == len) ? !wl[i] : wl[i]);
        exp_resp = !ok ? 2'b11 : (err ? 2'b10 : 2'b00);
        // data offered before the address must not be taken
        bus.S_AXI_WDATA  = wd[0];
        bus.S_AXI_WSTRB  = ws[0];
        bus.S_AXI_WLAST  = wl[0];
        bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_AWID   = id;
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_AWLEN  = 8'(len);
        bus.S_AXI_AWBURST = burst;
        bus.S_AXI_AWVALID = 1'b1;
        chk("wready_before_aw", 32'(bus.S_AXI_WREADY), 0);
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 50) begin tick(); n++; end
        if (!bus.S_AXI_AWREADY) begin
            chk("awready_timeout", 32'(bus.S_AXI_AWREADY), 1);
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
            return;
        end
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        chk("wready_after_aw", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 1);
        for (int unsigned i = 0; i <= len; i++) begin
            n = 0;
            while (gaps && n < 3 && $urandom_range(0, 2) == 0) begin
                bus.S_AXI_WVALID = 1'b0;
                tick();
                n++;
            end
            bus.S_AXI_WDATA  = wd[i];
            bus.S_AXI_WSTRB  = ws[i];
            bus.S_AXI_WLAST  = wl[i];
            bus.S_AXI_WVALID = 1'b1;
            if (!bus.S_AXI_WREADY) chk("wready_beat", 32'(bus.S_AXI_WREADY), 1);
            tick();
            if (ok) begin
                w = beat_word(addr, burst, i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST  = 1'b0;
        chk("bvalid_after_last_w", 32'({bus.S_AXI_BVALID, bus.S_AXI_WREADY}), 2);
        for (int unsigned d = 0; d < bdelay; d++) begin
            tick();
            chk("bvalid_hold", 32'(bus.S_AXI_BVALID), 1);
        end
        chk("bresp", 32'(bus.S_AXI_BRESP), 32'(exp_resp));
        chk("bid", 32'(bus.S_AXI_BID), 32'(id));
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        chk("b_done", 32'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY}), 1);
    endtask

    // Read burst; every presented beat is checked, including while stalled.
    task automatic axi_read(input logic id, input logic [31:0] addr, input int unsigned len,
                            input logic [1:0] burst, input bit stall, input int unsigned hold_first);
        logic [31:0] exp_q [$];
        bit          ok;
        bit          rr;
        bit          hs;
        int          first;
        int unsigned n, beat, cyc, held;
        ok = in_win(addr);
        for (int unsigned i = 0; i <= len; i++)
            exp_q.push_back(ok ? ref_mem[beat_word(addr, burst, i)] : 32'h0);
        bus.S_AXI_ARID    = id;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARLEN   = 8'(len);
        bus.S_AXI_ARBURST = burst;
        bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 50) begin tick(); n++; end
        if (!bus.S_AXI_ARREADY) begin
            chk("arready_timeout", 32'(bus.S_AXI_ARREADY), 1);
            bus.S_AXI_ARVALID = 1'b0;
            return;
        end
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        chk("arready_drop", 32'(bus.S_AXI_ARREADY), 0);
        beat = 0; cyc = 0; held = 0; first = -1; hs = 1'b0;
        while (beat <= len && cyc < 3000) begin
            if (hs) chk("rvalid_next_beat", 32'(bus.S_AXI_RVALID), 1);
            if (bus.S_AXI_RVALID) begin
                if (first < 0) begin
                    first = int'(cyc);
                    chk("r_latency", cyc, 2);
                end
                chk("rdata", bus.S_AXI_RDATA, exp_q[beat]);
                chk("rresp", 32'(bus.S_AXI_RRESP), ok ? 32'h0 : 32'h3);
                chk("rlast", 32'(bus.S_AXI_RLAST), 32'(beat == len));
                chk("rid", 32'(bus.S_AXI_RID), 32'(id));
                last_rdata = bus.S_AXI_RDATA;
            end
            rr = 1'b1;
            if (bus.S_AXI_RVALID && beat == 0 && held < hold_first) begin
                rr = 1'b0;
                held++;
            end else if (stall && $urandom_range(0, 3) == 0) begin
                rr = 1'b0;
            end
            bus.S_AXI_RREADY = rr;
            hs = bus.S_AXI_RVALID && rr;
            tick();
            cyc++;
            if (hs) beat++;
        end
        bus.S_AXI_RREADY = 1'b0;
        if (beat <= len) chk("r_timeout", beat, len + 1);
        chk("r_done", 32'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY}), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        int unsigned rlen;
        logic [1:0]  rburst;
        int unsigned n;

        bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0;
        bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0;
        bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        last_rdata = '0;
        apply_reset(3);

        // fill the whole memory with known random words, 256-beat bursts
        for (int unsigned blk = 0; blk < 16; blk++) begin
            for (int unsigned i = 0; i < 256; i++) begin
                wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 255);
            end
            axi_write(1'b0, BASE + 32'(blk * 1024), 255, 2'b01, 1'b0, 0);
        end

        // load a short program then fetch it back
        wd[0] = 32'h0000_0013; wd[1] = 32'h0010_0093;
        wd[2] = 32'h0020_0113; wd[3] = 32'h0030_8193;
        for (int unsigned i = 0; i < 4; i++) begin ws[i] = 4'hF; wl[i] = (i == 3); end
        axi_write(1'b1, BASE, 3, 2'b01, 1'b0, 0);
        axi_read(1'b1, BASE, 3, 2'b01, 1'b0, 0);
        chk("fetch_word3", last_rdata, 32'h0030_8193);

        // RREADY held low for three cycles on the first of two beats
        axi_read(1'b0, BASE + 32'h40, 1, 2'b01, 1'b0, 3);

        // byte strobes merge into an existing word
        wd[0] = 32'h1122_3344; ws[0] = 4'hF; wl[0] = 1'b1;
        axi_write(1'b0, BASE + 32'h100, 0, 2'b01, 1'b0, 0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
        axi_write(1'b0, BASE + 32'h100, 0, 2'b01, 1'b0, 1);
        axi_read(1'b0, BASE + 32'h100, 0, 2'b01, 1'b0, 0);
        chk("strb_merge", last_rdata, 32'h11BB_33DD);

        // decode errors on both paths; the bad write leaves word 0 alone
        axi_read(1'b1, 32'h1000_0000, 0, 2'b01, 1'b0, 0);
        chk("decerr_rdata", last_rdata, 32'h0);
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF; wl[0] = 1'b1;
        axi_write(1'b1, 32'h3000_0000, 0, 2'b01, 1'b0, 0);
        axi_read(1'b0, BASE, 0, 2'b01, 1'b0, 0);
        chk("decerr_mem_unchanged", last_rdata, 32'h0000_0013);

        // FIXED burst onto the last word, then INCR wrap past the end
        wd[0] = 32'hC0DE_0001; wd[1] = 32'hC0DE_0002; wd[2] = 32'hC0DE_0003;
        for (int unsigned i = 0; i < 3; i++) begin ws[i] = 4'hF; wl[i] = (i == 2); end
        axi_write(1'b0, BASE + 32'h3FFC, 2, 2'b00, 1'b0, 0);
        axi_read(1'b0, BASE + 32'h3FFC, 0, 2'b01, 1'b0, 0);
        chk("fixed_last_beat", last_rdata, 32'hC0DE_0003);
        axi_read(1'b0, BASE + 32'h3FFC, 1, 2'b01, 1'b0, 0);
        chk("incr_wrap_word0", last_rdata, 32'h0000_0013);

        // early and missing WLAST both give SLVERR
        for (int unsigned i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        wl[0] = 1'b0; wl[1] = 1'b1; wl[2] = 1'b0;
        axi_write(1'b1, BASE + 32'h200, 2, 2'b01, 1'b0, 0);
        wl[0] = 1'b0; wl[1] = 1'b0;
        axi_write(1'b0, BASE + 32'h300, 1, 2'b01, 1'b0, 0);

        // reset during beat 2 of a 4-beat read
        bus.S_AXI_ARID = 1'b0; bus.S_AXI_ARADDR = BASE; bus.S_AXI_ARLEN = 8'd3;
        bus.S_AXI_ARBURST = 2'b01; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 10) begin tick(); n++; end
        chk("rst_test_beat1", 32'(bus.S_AXI_RVALID), 1);
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        chk("rst_test_beat2", 32'({bus.S_AXI_RVALID, bus.S_AXI_RLAST}), 2);
        rst = 1'b1;
        tick();
        chk("rvalid_after_rst", 32'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY}), 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}), 3);
        axi_read(1'b1, BASE, 3, 2'b01, 1'b0, 0);
        chk("read_after_rst", last_rdata, 32'h0030_8193);

        // read and write running at the same time on disjoint words
        for (int unsigned i = 0; i < 8; i++) begin
            wd[i] = $urandom; ws[i] = 4'hF; wl[i] = (i == 7);
        end
        fork
            axi_write(1'b1, BASE + 32'h800, 7, 2'b01, 1'b1, 2);
            axi_read(1'b0, BASE + 32'h200, 7, 2'b10, 1'b1, 0);
        join
        axi_read(1'b0, BASE + 32'h800, 7, 2'b01, 1'b0, 0);

        // randomized traffic
        for (int unsigned t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            rlen   = $urandom_range(0, 15);
            rburst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                for (int unsigned i = 0; i <= rlen; i++) begin
                    wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); wl[i] = (i == rlen);
                end
                if ($urandom_range(0, 7) == 0) begin
                    n = $urandom_range(0, rlen);
                    wl[n] = !wl[n];
                end
                axi_write(1'($urandom_range(0, 1)), ra, rlen, rburst, 1'b1, $urandom_range(0, 3));
            end else begin
                axi_read(1'($urandom_range(0, 1)), ra, rlen, rburst, 1'($urandom_range(0, 1)), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
